// File: rtl/prime_check.sv
// Trial-division primality tester; drives an external divmod unit over a
// go/ready handshake and reports the smallest divisor found.
module prime_check #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] n,
    output logic             ready,
    output logic             error,
    output logic             is_prime,
    output logic [WIDTH-1:0] factor,
    output logic             dm_go,
    output logic [WIDTH-1:0] dm_a,
    output logic [WIDTH-1:0] dm_b,
    input  logic             dm_ready,
    input  logic             dm_error,
    input  logic [WIDTH-1:0] dm_div,
    input  logic [WIDTH-1:0] dm_mod
);

    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_ready;
    logic             r_error;
    logic             r_is_prime;
    logic [WIDTH-1:0] r_factor;
    logic             r_dm_go;
    logic [WIDTH-1:0] r_dm_a;
    logic [WIDTH-1:0] r_dm_b;
    logic [WIDTH-1:0] r_d;
    logic [TW-1:0]    r_timer;

    logic [WIDTH-1:0] w_d_next;

    assign w_d_next = r_d + WIDTH'(1);

    assign ready    = r_ready;
    assign error    = r_error;
    assign is_prime = r_is_prime;
    assign factor   = r_factor;
    assign dm_go    = r_dm_go;
    assign dm_a     = r_dm_a;
    assign dm_b     = r_dm_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ready    <= 1'b1;
            r_error    <= 1'b0;
            r_is_prime <= 1'b0;
            r_factor   <= '0;
            r_dm_go    <= 1'b0;
            r_dm_a     <= '0;
            r_dm_b     <= '0;
            r_d        <= WIDTH'(2);
            r_timer    <= '0;
        end else begin
            r_dm_go <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_dm_a  <= n;
                        r_d     <= WIDTH'(2);
                        r_error <= 1'b0;
                        r_ready <= 1'b0;
                        if (n < WIDTH'(2)) begin
                            r_is_prime <= 1'b0;
                            r_factor   <= '0;
                            r_state    <= S_DONE;
                        end else begin
                            r_dm_b  <= WIDTH'(2);
                            r_dm_go <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // divmod still shows its stale ready in the first cycle
                    if (r_timer == '0) begin
                        r_timer <= TW'(1);
                    end else if (dm_ready) begin
                        if (dm_error) begin
                            r_ready    <= 1'b1;
                            r_error    <= 1'b1;
                            r_is_prime <= 1'b0;
                            r_factor   <= '0;
                            r_state    <= S_IDLE;
                        end else if (dm_div < r_d) begin
                            r_ready    <= 1'b1;
                            r_is_prime <= 1'b1;
                            r_factor   <= r_dm_a;
                            r_state    <= S_IDLE;
                        end else if (dm_mod == '0) begin
                            r_ready    <= 1'b1;
                            r_is_prime <= 1'b0;
                            r_factor   <= r_d;
                            r_state    <= S_IDLE;
                        end else begin
                            r_d     <= w_d_next;
                            r_dm_b  <= w_d_next;
                            r_dm_go <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_ready    <= 1'b1;
                        r_error    <= 1'b1;
                        r_is_prime <= 1'b0;
                        r_factor   <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prime_check.sv
// Directed bench for prime_check with a behavioural divmod that can be
// switched to a stuck-busy or error-returning stub.
module tb_prime_check;

    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 3;
    localparam int BUDGET  = 3000;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             go  = 1'b0;
    logic [WIDTH-1:0] n   = '0;
    logic             ready;
    logic             error;
    logic             is_prime;
    logic [WIDTH-1:0] factor;
    logic             dm_go;
    logic [WIDTH-1:0] dm_a;
    logic [WIDTH-1:0] dm_b;
    logic             dm_ready = 1'b1;
    logic             dm_error = 1'b0;
    logic [WIDTH-1:0] dm_div   = '0;
    logic [WIDTH-1:0] dm_mod   = '0;

    int n_vec  = 0;
    int n_miss = 0;
    int pulses = 0;
    int cyc;

    // 0 = normal divider, 1 = never returns, 2 = returns error
    int dm_mode = 0;
    int m_cnt   = 0;
    logic [WIDTH-1:0] m_a = '0;
    logic [WIDTH-1:0] m_b = '0;

    int spf [0:200];

    prime_check #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .n        (n),
        .ready    (ready),
        .error    (error),
        .is_prime (is_prime),
        .factor   (factor),
        .dm_go    (dm_go),
        .dm_a     (dm_a),
        .dm_b     (dm_b),
        .dm_ready (dm_ready),
        .dm_error (dm_error),
        .dm_div   (dm_div),
        .dm_mod   (dm_mod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (dm_go) pulses <= pulses + 1;
    end

    always @(posedge clk) begin
        if (rst) begin
            dm_ready <= 1'b1;
            dm_error <= 1'b0;
            m_cnt    <= 0;
        end else if (dm_ready) begin
            if (dm_go) begin
                dm_ready <= 1'b0;
                m_a      <= dm_a;
                m_b      <= dm_b;
                m_cnt    <= LAT;
            end
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (dm_mode != 1) begin
            dm_ready <= 1'b1;
            dm_error <= (m_b == '0) || (dm_mode == 2);
            dm_div   <= (m_b == '0) ? '1 : m_a / m_b;
            dm_mod   <= (m_b == '0) ? m_a : m_a % m_b;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start(input logic [WIDTH-1:0] v);
        @(negedge clk);
        pulses = 0;
        go     = 1'b1;
        n      = v;
        @(negedge clk);
        go     = 1'b0;
    endtask

    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (!ready && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
        end
        if (!ready) check("wait_budget", 32'(cnt), 32'(BUDGET + 1));
    endtask

    task automatic run(input logic [WIDTH-1:0] v, input logic exp_p,
                       input logic [WIDTH-1:0] exp_f, input string tag);
        start(v);
        wait_ready(cyc);
        check({tag, "_err"}, 32'(error), 32'd0);
        check({tag, "_prime"}, 32'(is_prime), 32'(exp_p));
        check({tag, "_factor"}, 32'(factor), 32'(exp_f));
    endtask

    initial begin : main
        logic [WIDTH-1:0] pv [5];
        logic [WIDTH-1:0] cv [4];
        logic [WIDTH-1:0] cf [4];
        pv = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd97};
        cv = '{16'd4, 16'd9, 16'd25, 16'd91};
        cf = '{16'd2, 16'd3, 16'd5, 16'd7};

        for (int i = 0; i <= 200; i++) spf[i] = 0;
        for (int i = 2; i <= 200; i++) begin
            if (spf[i] == 0) begin
                for (int j = i; j <= 200; j += i) begin
                    if (spf[j] == 0) spf[j] = i;
                end
            end
        end

        do_reset();
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_prime", 32'(is_prime), 32'd0);
        check("rst_factor", 32'(factor), 32'd0);
        check("rst_dm_go", 32'(dm_go), 32'd0);
        check("rst_dm_a", 32'(dm_a), 32'd0);
        check("rst_dm_b", 32'(dm_b), 32'd0);

        for (int v = 0; v < 2; v++) begin
            start(WIDTH'(v));
            check("small_busy", 32'(ready), 32'd0);
            wait_ready(cyc);
            check("small_lat", 32'(cyc), 32'd1);
            check("small_prime", 32'(is_prime), 32'd0);
            check("small_factor", 32'(factor), 32'd0);
            check("small_pulses", 32'(pulses), 32'd0);
        end

        for (int i = 0; i < 5; i++) run(pv[i], 1'b1, pv[i], "prime");
        check("p97_pulses", 32'(pulses), 32'd9);

        for (int i = 0; i < 4; i++) run(cv[i], 1'b0, cf[i], "comp");

        for (int v = 0; v <= 200; v++) begin
            run(WIDTH'(v), (v >= 2) && (spf[v] == v),
                (v < 2) ? '0 : WIDTH'(spf[v]), "sweep");
        end

        dm_mode = 1;
        start(16'd7);
        wait_ready(cyc);
        check("to_cycles", 32'(cyc + 1), 32'(TIMEOUT + 2));
        check("to_error", 32'(error), 32'd1);
        check("to_prime", 32'(is_prime), 32'd0);
        dm_mode = 0;
        do_reset();

        dm_mode = 2;
        start(16'd9);
        wait_ready(cyc);
        check("dmerr_error", 32'(error), 32'd1);
        check("dmerr_prime", 32'(is_prime), 32'd0);
        dm_mode = 0;
        do_reset();

        start(16'd65521);
        repeat (6) @(negedge clk);
        check("mid_busy", 32'(ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_ready", 32'(ready), 32'd1);
        check("mrst_error", 32'(error), 32'd0);
        check("mrst_dm_go", 32'(dm_go), 32'd0);
        @(negedge clk);
        check("mrst_dm_go2", 32'(dm_go), 32'd0);
        run(16'd6, 1'b0, 16'd2, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
